// File: rtl/fp_norm_round.sv
// Post-normalization and round-to-nearest-even stage behind the FP adder.
// Two register stages with valid/ready flow control: normalize, then round/classify/pack.
module fp_norm_round #(
  parameter int unsigned C_EXP          = 8,
  parameter int unsigned C_MANT         = 23,
  parameter int unsigned C_EXP_PRENORM  = 10,
  parameter int unsigned C_MANT_PRENORM = 48
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        sign_i,
  input  logic [C_EXP_PRENORM-1:0]    exp_i,
  input  logic [C_MANT_PRENORM-1:0]   mant_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [C_EXP+C_MANT:0]       result_o,
  output logic                        ovf_o,
  output logic                        uf_o,
  output logic                        zero_o,
  output logic                        inexact_o
);

  localparam int unsigned EW  = C_EXP_PRENORM + 1;
  localparam int unsigned PW  = $clog2(C_MANT_PRENORM);
  localparam int unsigned HID = C_MANT_PRENORM - 2;
  localparam int unsigned NW  = HID;
  localparam int unsigned GRD = HID - C_MANT - 1;
  localparam int unsigned FW  = C_MANT + 1;
  localparam int unsigned RW  = 1 + C_EXP + C_MANT;
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << C_EXP) - 1);

  // Stage-1 registers: bits below the hidden one only, the hidden bit is implied.
  logic                 s1_valid;
  logic                 s1_sign;
  logic                 s1_zero;
  logic                 s1_sticky;
  logic signed [EW-1:0] s1_exp;
  logic [NW-1:0]        s1_mant;

  logic stage2_load;
  logic stage1_load;

  assign stage2_load = ~valid_o | ready_i;
  assign stage1_load = ~s1_valid | stage2_load;
  assign ready_o     = stage1_load;

  // Leading-one detect and normalizing shift.
  logic [PW-1:0]        lead;
  logic [PW-1:0]        shamt;
  logic [NW-1:0]        norm;
  logic                 shifted_out;
  logic signed [EW-1:0] e_norm;

  always_comb begin
    lead = '0;
    for (int i = 0; i < C_MANT_PRENORM; i++) begin
      if (mant_i[i]) lead = PW'(i);
    end
    shamt       = PW'(HID) - lead;
    shifted_out = 1'b0;
    if (lead == PW'(HID + 1)) begin
      norm        = NW'(mant_i >> 1);
      shifted_out = mant_i[0];
    end else begin
      norm = NW'(mant_i << shamt);
    end
    e_norm = EW'($signed(exp_i)) + $signed(EW'(lead)) - $signed(EW'(HID));
  end

  // Round to nearest even, then classify and pack.
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FW-1:0]        frac_inc;
  logic signed [EW-1:0] e_rnd;
  logic [RW-1:0]        result_n;
  logic                 ovf_n;
  logic                 uf_n;
  logic                 zero_n;
  logic                 inexact_n;

  always_comb begin
    guard     = s1_mant[GRD];
    sticky    = (|s1_mant[GRD-1:0]) | s1_sticky;
    round_up  = guard & (sticky | s1_mant[GRD+1]);
    frac_inc  = {1'b0, s1_mant[NW-1 -: C_MANT]} + FW'(round_up);
    e_rnd     = s1_exp + $signed(EW'(frac_inc[C_MANT]));
    result_n  = '0;
    ovf_n     = 1'b0;
    uf_n      = 1'b0;
    zero_n    = 1'b0;
    inexact_n = 1'b0;
    if (s1_zero) begin
      zero_n = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      result_n  = {s1_sign, {(RW-1){1'b0}}};
      uf_n      = 1'b1;
      inexact_n = 1'b1;
    end else if (e_rnd >= E_MAX) begin
      result_n  = {s1_sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
      ovf_n     = 1'b1;
      inexact_n = 1'b1;
    end else begin
      result_n  = {s1_sign, e_rnd[C_EXP-1:0], frac_inc[C_MANT-1:0]};
      inexact_n = guard | sticky;
    end
  end

  // Pipeline registers; stage 2 drains while stage 1 refills in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sticky <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      valid_o   <= 1'b0;
      result_o  <= '0;
      ovf_o     <= 1'b0;
      uf_o      <= 1'b0;
      zero_o    <= 1'b0;
      inexact_o <= 1'b0;
    end else begin
      if (stage1_load) begin
        s1_valid <= valid_i;
        if (valid_i) begin
          s1_sign   <= sign_i;
          s1_zero   <= (mant_i == '0);
          s1_sticky <= shifted_out;
          s1_exp    <= e_norm;
          s1_mant   <= norm;
        end
      end
      if (stage2_load) begin
        valid_o <= s1_valid;
        if (s1_valid) begin
          result_o  <= result_n;
          ovf_o     <= ovf_n;
          uf_o      <= uf_n;
          zero_o    <= zero_n;
          inexact_o <= inexact_n;
        end
      end
    end
  end

endmodule

// File: doc/fp_norm_round.md
# fp_norm_round

Pipelined post-normalization and rounding stage directly downstream of the floating-point adder. It consumes the adder's pre-normalized sign, signed exponent and wide mantissa, then normalizes, rounds to nearest-even and packs a binary32-style result with status flags. Handshake is valid/ready with two register stages. Throughput is one result per cycle.

## Interface
- C_EXP, 8, biased exponent width of the packed result
- C_MANT, 23, fraction width of the packed result (hidden bit excluded)
- C_EXP_PRENORM, 10, signed pre-norm exponent width (C_EXP+2)
- C_MANT_PRENORM, 48, pre-norm mantissa width (2*C_MANT+2)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- valid_i  in  1  input operand valid
- ready_o  out  1  block can accept an input this cycle
- sign_i  in  1  pre-norm sign
- exp_i  in  C_EXP_PRENORM  signed pre-norm biased exponent
- mant_i  in  C_MANT_PRENORM  pre-norm mantissa
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  1+C_EXP+C_MANT  packed {sign, exp, frac}
- ovf_o, uf_o, zero_o, inexact_o  out  1 each  overflow, underflow (flush), exact zero, inexact

## Operation
- Mantissa format:
  - bit 47: carry.
  - bit 46: hidden bit (value 1.f at exp_i).
  - bits 45:23: fraction.
  - bit 22: guard.
  - bits 21:0: sticky field.
- Stage 1 (normalize):
  - Find the leading-one position p in 0..47.
  - Compute E = exp_i + p - 46 at C_EXP_PRENORM+1 bits, signed.
  - If p==47, shift right by 1 and OR the shifted-out bit into sticky.
  - If p<46, shift left by 46-p.
  - If mant_i==0, mark the operand zero.
- Stage 2 (round, classify, pack):
  - G = bit 22; S = |bits 21:0 | shifted-out bit; L = bit 23.
  - Round up iff G & (S | L).
  - If the fraction carries out of all-ones: frac=0, E=E+1.
- Classification, first match wins:
  - Zero: result_o = 0 (+0), zero_o=1, other flags 0.
  - E <= 0: flush to {sign,0,0}, uf_o=1, inexact_o=1.
  - E >= 2^C_EXP-1 after rounding: {sign, all-ones, 0} (infinity), ovf_o=1, inexact_o=1.
  - Otherwise: {sign, E[C_EXP-1:0], frac}, inexact_o = G|S.
- Flags are valid only with valid_o.

## Timing
- Reset (rst_i sampled high at a clock edge):
  - Both stage valids clear and valid_o=0.
  - result_o and all flags are 0.
  - In-flight data is discarded.
  - ready_o=1 the cycle after reset is released.
- Accept rule: an input is accepted on a cycle with valid_i & ready_o.
- Latency and throughput:
  - Latency is 2 cycles from acceptance to valid_o with no stall.
  - Back-to-back inputs yield back-to-back outputs.
- Stage-2 load:
  - Stage 2 loads when ~valid_o | ready_i.
- Stage-1 load:
  - Stage 1 loads when ~s1_valid | stage2_load.
- ready_o:
  - ready_o = ~s1_valid | stage2_load.
  - It is a combinational function of ready_i; this path is permitted.
  - Bubbles collapse: an empty stage never blocks.
- Output hold:
  - While valid_o & ~ready_i, result_o and the flags hold stable.
  - At most 2 results are buffered.
  - No data is lost or reordered.
- Simultaneous stage-2 drain and stage-1 refill in one cycle is required: full throughput under ready_i=1.
- Inputs are sampled only on acceptance. sign_i, exp_i and mant_i are don't-care otherwise.

## Test plan
- 1.0+1.0: exp_i=127, mant_i=48'h8000_0000_0000 -> result_o=32'h4000_0000, all flags 0, valid_o exactly 2 cycles after acceptance.
- Rounding ties:
  - exp_i=127, mant_i=48'h4000_0040_0000 (tie, L=0) -> 32'h3F80_0000, inexact_o=1.
  - mant_i=48'h4000_00C0_0000 (tie, L=1) -> 32'h3F80_0002, inexact_o=1.
- Overflow and zero:
  - exp_i=254, mant_i=48'h8000_0000_0000, sign_i=1 -> 32'hFF80_0000, ovf_o=1.
  - mant_i=0 with any exp_i -> 32'h0000_0000, zero_o=1.
- Underflow: exp_i=1, mant_i=48'h2000_0000_0000, sign_i=1 -> E=0 -> 32'h8000_0000, uf_o=1, inexact_o=1.
- Backpressure: stream 4 operands with valid_i=1 and ready_i=0 for 3 cycles.
  - ready_o drops after 2 are accepted.
  - result_o stays stable while stalled.
  - After ready_i=1, all 4 results appear in order with no gaps.
- Reset mid-stream: assert rst_i with both stages full.
  - Next cycle valid_o=0 and result_o=0.
  - No stale result emerges afterwards.
